rv32i_hazard_scoreboard: RTL and testbench
==========================================

Name: rv32i_hazard_scoreboard

Overview:
- Parametrised hazard-detection unit for the RV32I in-order pipeline.
- Tracks in-flight register writes through NB_STAGES post-decode stages (EXEC..WB) in a shift-register scoreboard.
- Raises a decode stall on RAW dependencies; optionally emits bypass selects so only load-use hazards stall.
- Sits beside the control path; consumes decoded operand/destination info from DEC, plus flush and memory-stall events.

Parameters:
- NB_STAGES, 3: number of tracked stages after DEC. Index 0 = EXEC, NB_STAGES-1 = WB. Legal range 2..8.
- LOAD_FWD_STAGE, 2: first stage index at which load data can be bypassed. Must be ≤ NB_STAGES-1.
- SELW, $clog2(NB_STAGES+1): width of the forwarding selects.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  asynchronous reset, active-high.
- dec_valid_i  in  1  DEC holds a real instruction.
- dec_rs1_i  in  5  rs1 address.
- dec_rs1_re_i  in  1  instruction reads rs1.
- dec_rs2_i  in  5  rs2 address.
- dec_rs2_re_i  in  1  instruction reads rs2.
- dec_rd_i  in  5  rd address.
- dec_rd_we_i  in  1  instruction writes rd.
- dec_is_load_i  in  1  instruction is a load.
- flush_i  in  1  branch/jump redirect; DEC instruction is killed.
- stall_ext_i  in  1  memory stall; freezes stages 0..NB_STAGES-2.
- stall_o  out  1  hold PC/IF/DEC and insert a bubble into EXEC.
- fwd_rs1_sel_o  out  SELW  0 = register file, k+1 = result of stage k.
- fwd_rs2_sel_o  out  SELW  same encoding, for rs2.
- wb_rd_o  out  5  rd of the WB entry.
- wb_we_o  out  1  WB entry valid (register write this cycle).
- busy_o  out  1  any scoreboard entry valid.
- stall_cnt_o  out  32  saturating count of cycles with stall_o=1.

Behaviour:
- Scoreboard entries: entry[k] = {valid, rd[4:0], load}.
- Reset (rst_i=1, asynchronous): all entries invalid, stall_cnt_o=0. Hence stall_o=0, fwd selects 0, wb_we_o=0, wb_rd_o=0, busy_o=0. Reset mid-operation discards all pending entries immediately.
- Issue condition: issue = dec_valid_i & ~stall_o & ~flush_i.
- New entry: valid = issue & dec_rd_we_i & (dec_rd_i≠0). rd = dec_rd_i, load = dec_is_load_i. An x0 destination never creates an entry, so x0 never causes a stall.
- Clock edge with stall_ext_i=0: entry[0] ← new entry, or a bubble if there is no issue. entry[k] ← entry[k-1] for k≥1.
- Clock edge with stall_ext_i=1: entries 0..NB_STAGES-2 hold; entry[NB_STAGES-1] ← bubble. Nothing enters; flush_i is ignored and must be held by its source until stall_ext_i falls.
- wb_rd_o and wb_we_o are driven combinationally from entry[NB_STAGES-1]. Register-file write is same-cycle, with no internal write-through.
- match_rsX(k) = dec_rsX_re_i & entry[k].valid & (entry[k].rd == dec_rsX_i).
- stall_o without forwarding: OR over all k and both sources of match_rsX(k), gated by dec_valid_i & ~flush_i. A match in WB also stalls (1 cycle).
- stall_o is combinational; latency from hazard appearance to stall_o is 0 cycles.
- Every dependency clears after at most NB_STAGES stall cycles, so there is no deadlock.
- stall_cnt_o increments by 1 on each clock edge where stall_o=1 and saturates at 0xFFFFFFFF.
- busy_o = OR of all entry valids.

Optional Feature:
- Macro: RV32I_HAZARD_FORWARDING_EN.
- Defined:
  - For each source, select the youngest (lowest k) matching entry.
  - If that entry has load=1 and k<LOAD_FWD_STAGE, stall.
  - Otherwise fwd_rsX_sel_o = k+1 and no stall for that source.
  - fwd_rsX_sel_o is 0 when there is no match, or while stall_o=1.
- Not defined: fwd selects tied to 0; stall on any match as described above.

Test Plan:
- Reset then idle: rst_i 1→0 → all outputs 0, busy_o=0.
- No forwarding, `addi x5,x0,1` then `add x6,x5,x5` back-to-back → stall_o=1 for 3 cycles (x5 in stages 0, 1, 2), then the add issues; stall_cnt_o=3.
- Forwarding on, same sequence → stall_o=0, fwd_rs1_sel_o=fwd_rs2_sel_o=1.
- Forwarding on:
  - `lw x7,0(x1)` then `add x8,x7,x0` → stall_o=1 for 2 cycles (x7 in stages 0, 1).
  - The add then issues with fwd_rs1_sel_o=3 (WB).
- Destination x0:
  - Write to x0 followed by a reader of x0 → no stall, no entry created; wb_we_o stays 0.
- Flush and memory stall:
  - flush_i=1 with a valid `addi x9,...` in DEC → no entry; next cycle busy_o=0.
  - stall_ext_i=1 for 2 cycles with x5 in entry[0] → x5 stays in entry[0]; WB shows bubbles (wb_we_o=0).

Source files
------------

// File: rtl/rv32i_hazard_scoreboard.sv
// RAW hazard scoreboard for the RV32I in-order pipeline: tracks in-flight rd writes EXEC..WB.
// Define RV32I_HAZARD_FORWARDING_EN to emit bypass selects so only early load-use hazards stall.
module rv32i_hazard_scoreboard #(
   parameter int NB_STAGES      = 3,
   parameter int LOAD_FWD_STAGE = 2,
   parameter int SELW           = $clog2(NB_STAGES + 1)
) (
   input  logic            clk_i,
   input  logic            rst_i,
   input  logic            dec_valid_i,
   input  logic [4:0]      dec_rs1_i,
   input  logic            dec_rs1_re_i,
   input  logic [4:0]      dec_rs2_i,
   input  logic            dec_rs2_re_i,
   input  logic [4:0]      dec_rd_i,
   input  logic            dec_rd_we_i,
   input  logic            dec_is_load_i,
   input  logic            flush_i,
   input  logic            stall_ext_i,
   output logic            stall_o,
   output logic [SELW-1:0] fwd_rs1_sel_o,
   output logic [SELW-1:0] fwd_rs2_sel_o,
   output logic [4:0]      wb_rd_o,
   output logic            wb_we_o,
   output logic            busy_o,
   output logic [31:0]     stall_cnt_o
);

   typedef struct packed {
      logic       valid;
      logic [4:0] rd;
      logic       load;
   } entry_t;

   entry_t [NB_STAGES-1:0] sb;
   entry_t                 new_e;
   logic [NB_STAGES-1:0]   m1, m2, vld;
   logic                   issue;

   always_comb begin
      m1  = '0;
      m2  = '0;
      vld = '0;
      for (int k = 0; k < NB_STAGES; k++) begin
         m1[k]  = dec_rs1_re_i & sb[k].valid & (sb[k].rd == dec_rs1_i);
         m2[k]  = dec_rs2_re_i & sb[k].valid & (sb[k].rd == dec_rs2_i);
         vld[k] = sb[k].valid;
      end
   end

   assign issue = dec_valid_i & ~stall_o & ~flush_i;

   // Bubbles are stored all-zero so wb_rd_o reads 0 whenever WB is empty.
   always_comb begin
      new_e = '0;
      if (issue && dec_rd_we_i && (dec_rd_i != 5'd0)) begin
         new_e.valid = 1'b1;
         new_e.rd    = dec_rd_i;
         new_e.load  = dec_is_load_i;
      end
   end

`ifdef RV32I_HAZARD_FORWARDING_EN
   logic [SELW-1:0] sel1, sel2;
   logic            haz1, haz2;

   // Walk oldest to youngest so the lowest matching stage wins.
   always_comb begin
      sel1 = '0;
      sel2 = '0;
      haz1 = 1'b0;
      haz2 = 1'b0;
      for (int k = NB_STAGES - 1; k >= 0; k--) begin
         if (m1[k]) begin
            sel1 = SELW'(k + 1);
            haz1 = sb[k].load & (k < LOAD_FWD_STAGE);
         end
         if (m2[k]) begin
            sel2 = SELW'(k + 1);
            haz2 = sb[k].load & (k < LOAD_FWD_STAGE);
         end
      end
   end

   assign stall_o       = dec_valid_i & ~flush_i & (haz1 | haz2);
   assign fwd_rs1_sel_o = stall_o ? '0 : sel1;
   assign fwd_rs2_sel_o = stall_o ? '0 : sel2;
`else
   logic unused_load;

   always_comb begin
      unused_load = (LOAD_FWD_STAGE > 0);
      for (int k = 0; k < NB_STAGES; k++) unused_load = unused_load ^ sb[k].load;
   end

   assign stall_o       = dec_valid_i & ~flush_i & ((|m1) | (|m2));
   assign fwd_rs1_sel_o = '0;
   assign fwd_rs2_sel_o = '0;
`endif

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         sb          <= '0;
         stall_cnt_o <= '0;
      end else begin
         if (stall_o && (stall_cnt_o != 32'hFFFF_FFFF)) stall_cnt_o <= stall_cnt_o + 32'd1;
         // A memory stall freezes EXEC..MEM while WB retires into a bubble.
         if (stall_ext_i) begin
            sb[NB_STAGES-1] <= '0;
         end else begin
            sb[0] <= new_e;
            for (int k = 1; k < NB_STAGES; k++) sb[k] <= sb[k-1];
         end
      end
   end

   assign wb_rd_o = sb[NB_STAGES-1].rd;
   assign wb_we_o = sb[NB_STAGES-1].valid;
   assign busy_o  = |vld;

endmodule

// File: tb/tb_rv32i_hazard_scoreboard.sv
// Directed bench for rv32i_hazard_scoreboard; expectations follow the build's forwarding macro.
module tb_rv32i_hazard_scoreboard;

`ifdef RV32I_HAZARD_FORWARDING_EN
   localparam bit FWD = 1'b1;
`else
   localparam bit FWD = 1'b0;
`endif

   logic        clk, rst;
   logic        dec_valid, dec_rs1_re, dec_rs2_re, dec_rd_we, dec_is_load;
   logic [4:0]  dec_rs1, dec_rs2, dec_rd;
   logic        flush, stall_ext;
   logic        stall;
   logic [1:0]  sel1, sel2;
   logic [4:0]  wb_rd;
   logic        wb_we, busy;
   logic [31:0] cnt;

   int n_chk  = 0;
   int n_fail = 0;

   rv32i_hazard_scoreboard dut (
      .clk_i(clk), .rst_i(rst),
      .dec_valid_i(dec_valid), .dec_rs1_i(dec_rs1), .dec_rs1_re_i(dec_rs1_re),
      .dec_rs2_i(dec_rs2), .dec_rs2_re_i(dec_rs2_re), .dec_rd_i(dec_rd),
      .dec_rd_we_i(dec_rd_we), .dec_is_load_i(dec_is_load),
      .flush_i(flush), .stall_ext_i(stall_ext),
      .stall_o(stall), .fwd_rs1_sel_o(sel1), .fwd_rs2_sel_o(sel2),
      .wb_rd_o(wb_rd), .wb_we_o(wb_we), .busy_o(busy), .stall_cnt_o(cnt)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic idle;
      dec_valid = 0; dec_rs1 = 0; dec_rs1_re = 0; dec_rs2 = 0; dec_rs2_re = 0;
      dec_rd = 0; dec_rd_we = 0; dec_is_load = 0;
   endtask

   task automatic drive(input logic [4:0] rd, input logic [4:0] rs1, input logic re1,
                        input logic [4:0] rs2, input logic re2, input logic ld);
      dec_valid = 1; dec_rd = rd; dec_rd_we = 1; dec_rs1 = rs1; dec_rs1_re = re1;
      dec_rs2 = rs2; dec_rs2_re = re2; dec_is_load = ld;
   endtask

   task automatic do_reset;
      idle(); flush = 0; stall_ext = 0; rst = 1;
      tick();
      rst = 0;
      #1;
   endtask

   task automatic test_reset;
      rst = 1; idle(); flush = 0; stall_ext = 0;
      tick(); tick();
      rst = 0;
      #1;
      n_chk++; if (stall !== 1'b0) begin n_fail++; $display("FAIL reset_stall got %b exp 0", stall); end
      n_chk++; if (sel1 !== 2'd0 || sel2 !== 2'd0) begin n_fail++; $display("FAIL reset_sel got %0d/%0d exp 0/0", sel1, sel2); end
      n_chk++; if (wb_we !== 1'b0 || wb_rd !== 5'd0) begin n_fail++; $display("FAIL reset_wb got we=%b rd=%0d exp 0/0", wb_we, wb_rd); end
      n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b exp 0", busy); end
      n_chk++; if (cnt !== 32'd0) begin n_fail++; $display("FAIL reset_cnt got %0d exp 0", cnt); end
   endtask

   // addi x5,x0,1 ; add x6,x5,x5
   task automatic test_raw_alu;
      int nst;
      nst = FWD ? 0 : 3;
      do_reset();
      drive(5, 0, 1, 0, 0, 0);
      #1;
      n_chk++; if (stall !== 1'b0) begin n_fail++; $display("FAIL raw_first_stall got %b exp 0", stall); end
      tick();
      drive(6, 5, 1, 5, 1, 0);
      for (int i = 0; i < nst; i++) begin
         #1;
         n_chk++; if (stall !== 1'b1) begin n_fail++; $display("FAIL raw_stall_cyc%0d got %b exp 1", i, stall); end
         tick();
      end
      #1;
      n_chk++; if (stall !== 1'b0) begin n_fail++; $display("FAIL raw_release got %b exp 0", stall); end
      n_chk++; if (sel1 !== (FWD ? 2'd1 : 2'd0) || sel2 !== (FWD ? 2'd1 : 2'd0))
         begin n_fail++; $display("FAIL raw_sel got %0d/%0d exp %0d", sel1, sel2, FWD ? 1 : 0); end
      n_chk++; if (cnt !== 32'(nst)) begin n_fail++; $display("FAIL raw_cnt got %0d exp %0d", cnt, nst); end
      tick();
      idle();
      #1;
      n_chk++; if (busy !== 1'b1) begin n_fail++; $display("FAIL raw_busy got %b exp 1", busy); end
   endtask

   // lw x7,0(x1) ; add x8,x7,x0
   task automatic test_load_use;
      int nst;
      nst = FWD ? 2 : 3;
      do_reset();
      drive(7, 1, 1, 0, 0, 1);
      tick();
      drive(8, 7, 1, 0, 1, 0);
      for (int i = 0; i < nst; i++) begin
         #1;
         n_chk++; if (stall !== 1'b1) begin n_fail++; $display("FAIL lu_stall_cyc%0d got %b exp 1", i, stall); end
         n_chk++; if (sel1 !== 2'd0) begin n_fail++; $display("FAIL lu_sel_during_stall got %0d exp 0", sel1); end
         tick();
      end
      #1;
      n_chk++; if (stall !== 1'b0) begin n_fail++; $display("FAIL lu_release got %b exp 0", stall); end
      n_chk++; if (sel1 !== (FWD ? 2'd3 : 2'd0) || sel2 !== 2'd0)
         begin n_fail++; $display("FAIL lu_sel got %0d/%0d exp %0d/0", sel1, sel2, FWD ? 3 : 0); end
      n_chk++; if (cnt !== 32'(nst)) begin n_fail++; $display("FAIL lu_cnt got %0d exp %0d", cnt, nst); end
      tick();
      idle();
   endtask

   task automatic test_x0;
      do_reset();
      drive(0, 0, 1, 0, 0, 0);
      tick();
      drive(0, 0, 1, 0, 1, 0);
      #1;
      n_chk++; if (stall !== 1'b0 || sel1 !== 2'd0) begin n_fail++; $display("FAIL x0_reader got stall=%b sel=%0d exp 0/0", stall, sel1); end
      tick();
      idle();
      for (int i = 0; i < 3; i++) begin
         #1;
         n_chk++; if (wb_we !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL x0_no_entry%0d got we=%b busy=%b exp 0/0", i, wb_we, busy); end
         tick();
      end
   endtask

   task automatic test_flush;
      do_reset();
      flush = 1;
      drive(9, 0, 1, 0, 0, 0);
      tick();
      flush = 0; idle();
      #1;
      n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL flush_busy got %b exp 0", busy); end
      drive(5, 0, 1, 0, 0, 0);
      tick();
      flush = 1;
      drive(9, 5, 1, 0, 0, 0);
      #1;
      n_chk++; if (stall !== 1'b0) begin n_fail++; $display("FAIL flush_gates_stall got %b exp 0", stall); end
      tick();
      flush = 0; idle();
      tick();
      n_chk++; if (wb_we !== 1'b1 || wb_rd !== 5'd5) begin n_fail++; $display("FAIL flush_wb_x5 got we=%b rd=%0d exp 1/5", wb_we, wb_rd); end
      tick();
      n_chk++; if (wb_we !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL flush_no_x9 got we=%b busy=%b exp 0/0", wb_we, busy); end
   endtask

   task automatic test_mem_stall;
      do_reset();
      drive(5, 0, 1, 0, 0, 0);
      tick();
      stall_ext = 1;
      drive(10, 0, 1, 0, 0, 0);
      for (int i = 0; i < 2; i++) begin
         #1;
         n_chk++; if (wb_we !== 1'b0 || busy !== 1'b1) begin n_fail++; $display("FAIL ms_hold%0d got we=%b busy=%b exp 0/1", i, wb_we, busy); end
         tick();
      end
      stall_ext = 0; idle();
      n_chk++; if (cnt !== 32'd0) begin n_fail++; $display("FAIL ms_cnt got %0d exp 0", cnt); end
      tick();
      n_chk++; if (wb_we !== 1'b0) begin n_fail++; $display("FAIL ms_wb_early got %b exp 0", wb_we); end
      tick();
      n_chk++; if (wb_we !== 1'b1 || wb_rd !== 5'd5) begin n_fail++; $display("FAIL ms_wb_x5 got we=%b rd=%0d exp 1/5", wb_we, wb_rd); end
      tick();
      n_chk++; if (wb_we !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL ms_no_x10 got we=%b busy=%b exp 0/0", wb_we, busy); end
   endtask

   task automatic test_reset_mid;
      do_reset();
      drive(5, 0, 1, 0, 0, 0);
      tick();
      drive(6, 0, 1, 0, 0, 0);
      tick();
      drive(7, 6, 1, 0, 0, 0);
      #1;
      n_chk++; if (busy !== 1'b1) begin n_fail++; $display("FAIL rmid_busy_pre got %b exp 1", busy); end
      #1 rst = 1;
      #1;
      n_chk++; if (busy !== 1'b0 || stall !== 1'b0) begin n_fail++; $display("FAIL rmid_async got busy=%b stall=%b exp 0/0", busy, stall); end
      n_chk++; if (cnt !== 32'd0) begin n_fail++; $display("FAIL rmid_cnt got %0d exp 0", cnt); end
      idle();
      tick();
      rst = 0;
   endtask

   initial begin
      test_reset();
      test_raw_alu();
      test_load_use();
      test_x0();
      test_flush();
      test_mem_stall();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
